// File: rtl/alu_slice_sequencer.sv
// alu_slice_sequencer: runs a wide ALU operation as a chain of 16-bit slices, LSB first.
// Build option ALU_SEQ_RESP_REG_EN registers the ALU response, making each slice two cycles.
module alu_slice_sequencer #(
    parameter int NUM_SLICES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    output logic                       ready_o,
    input  logic [16*NUM_SLICES-1:0]   op_a_i,
    input  logic [16*NUM_SLICES-1:0]   op_b_i,
    input  logic [3:0]                 op_select_i,
    input  logic                       op_mode_i,
    input  logic                       op_carry_in_i,
    output logic [15:0]                alu_in_a_o,
    output logic [15:0]                alu_in_b_o,
    output logic [3:0]                 alu_select_o,
    output logic                       alu_mode_o,
    output logic                       alu_carry_in_o,
    input  logic [15:0]                alu_result_i,
    input  logic                       alu_carry_out_i,
    input  logic                       alu_compare_i,
    output logic [16*NUM_SLICES-1:0]   result_o,
    output logic                       result_carry_o,
    output logic                       result_compare_o,
    output logic                       done_o
);

    localparam int W     = 16 * NUM_SLICES;
    localparam int IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       op_a_q, op_a_d;
    logic [W-1:0]       op_b_q, op_b_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               cmp_acc_q, cmp_acc_d;
    logic [15:0]        alu_in_a_q, alu_in_a_d;
    logic [15:0]        alu_in_b_q, alu_in_b_d;
    logic [3:0]         alu_select_q, alu_select_d;
    logic               alu_mode_q, alu_mode_d;
    logic               alu_carry_in_q, alu_carry_in_d;
    logic [W-1:0]       result_q, result_d;
    logic               result_carry_q, result_carry_d;
    logic               result_compare_q, result_compare_d;
    logic               done_q, done_d;

    logic [IDX_W-1:0]   idx_nxt_s;
    logic               last_s;
    logic               cap_en_s;
    logic [15:0]        cap_res_s;
    logic               cap_co_s;
    logic               cap_cmp_s;

    assign idx_nxt_s = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
    assign last_s    = (idx_q == IDX_W'(NUM_SLICES - 1));

`ifdef ALU_SEQ_RESP_REG_EN
    logic        phase_q;
    logic [15:0] resp_res_q;
    logic        resp_co_q;
    logic        resp_cmp_q;

    // Response register and drive/capture phase toggle for two-cycle slices
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q    <= 1'b0;
            resp_res_q <= 16'h0000;
            resp_co_q  <= 1'b0;
            resp_cmp_q <= 1'b0;
        end else begin
            resp_res_q <= alu_result_i;
            resp_co_q  <= alu_carry_out_i;
            resp_cmp_q <= alu_compare_i;
            if (state_q == S_RUN) begin
                phase_q <= ~phase_q;
            end else begin
                phase_q <= 1'b0;
            end
        end
    end

    assign cap_en_s  = (state_q == S_RUN) && phase_q;
    assign cap_res_s = resp_res_q;
    assign cap_co_s  = resp_co_q;
    assign cap_cmp_s = resp_cmp_q;
`else
    assign cap_en_s  = (state_q == S_RUN);
    assign cap_res_s = alu_result_i;
    assign cap_co_s  = alu_carry_out_i;
    assign cap_cmp_s = alu_compare_i;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (cap_en_s && last_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM output decode
    always_comb begin
        ready_o = 1'b0;
        case (state_q)
            S_IDLE:  ready_o = 1'b1;
            S_RUN:   ready_o = 1'b0;
            S_DONE:  ready_o = 1'b0;
            default: ready_o = 1'b0;
        endcase
    end

    // Datapath next-state: operand latch, slice drive, capture and reassembly
    always_comb begin
        op_a_d           = op_a_q;
        op_b_d           = op_b_q;
        idx_d            = idx_q;
        cmp_acc_d        = cmp_acc_q;
        alu_in_a_d       = alu_in_a_q;
        alu_in_b_d       = alu_in_b_q;
        alu_select_d     = alu_select_q;
        alu_mode_d       = alu_mode_q;
        alu_carry_in_d   = alu_carry_in_q;
        result_d         = result_q;
        result_carry_d   = result_carry_q;
        result_compare_d = result_compare_q;
        done_d           = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    op_a_d         = op_a_i;
                    op_b_d         = op_b_i;
                    idx_d          = '0;
                    cmp_acc_d      = 1'b1;
                    alu_in_a_d     = op_a_i[15:0];
                    alu_in_b_d     = op_b_i[15:0];
                    alu_select_d   = op_select_i;
                    alu_mode_d     = op_mode_i;
                    alu_carry_in_d = op_carry_in_i;
                end else begin
                    alu_in_a_d     = 16'h0000;
                    alu_in_b_d     = 16'h0000;
                    alu_select_d   = 4'h0;
                    alu_mode_d     = 1'b0;
                    alu_carry_in_d = 1'b0;
                end
            end
            S_RUN: begin
                if (cap_en_s) begin
                    result_d[{idx_q, 4'h0} +: 16] = cap_res_s;
                    cmp_acc_d = cmp_acc_q & cap_cmp_s;
                    idx_d     = idx_nxt_s;
                    if (last_s) begin
                        result_carry_d   = cap_co_s;
                        result_compare_d = cmp_acc_q & cap_cmp_s;
                        done_d           = 1'b1;
                        alu_in_a_d       = 16'h0000;
                        alu_in_b_d       = 16'h0000;
                        alu_select_d     = 4'h0;
                        alu_mode_d       = 1'b0;
                        alu_carry_in_d   = 1'b0;
                    end else begin
                        // The carry register doubles as the next slice's carry-in
                        alu_in_a_d     = op_a_q[{idx_nxt_s, 4'h0} +: 16];
                        alu_in_b_d     = op_b_q[{idx_nxt_s, 4'h0} +: 16];
                        alu_carry_in_d = cap_co_s;
                    end
                end else begin
                    done_d = 1'b0;
                end
            end
            S_DONE: begin
                done_d = 1'b0;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a_q           <= '0;
            op_b_q           <= '0;
            idx_q            <= '0;
            cmp_acc_q        <= 1'b0;
            alu_in_a_q       <= 16'h0000;
            alu_in_b_q       <= 16'h0000;
            alu_select_q     <= 4'h0;
            alu_mode_q       <= 1'b0;
            alu_carry_in_q   <= 1'b0;
            result_q         <= '0;
            result_carry_q   <= 1'b0;
            result_compare_q <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            op_a_q           <= op_a_d;
            op_b_q           <= op_b_d;
            idx_q            <= idx_d;
            cmp_acc_q        <= cmp_acc_d;
            alu_in_a_q       <= alu_in_a_d;
            alu_in_b_q       <= alu_in_b_d;
            alu_select_q     <= alu_select_d;
            alu_mode_q       <= alu_mode_d;
            alu_carry_in_q   <= alu_carry_in_d;
            result_q         <= result_d;
            result_carry_q   <= result_carry_d;
            result_compare_q <= result_compare_d;
            done_q           <= done_d;
        end
    end

    assign alu_in_a_o       = alu_in_a_q;
    assign alu_in_b_o       = alu_in_b_q;
    assign alu_select_o     = alu_select_q;
    assign alu_mode_o       = alu_mode_q;
    assign alu_carry_in_o   = alu_carry_in_q;
    assign result_o         = result_q;
    assign result_carry_o   = result_carry_q;
    assign result_compare_o = result_compare_q;
    assign done_o           = done_q;

endmodule
